noekeon_encrypt_core: RTL and testbench

Iterative Noekeon block-cipher encryption engine, direct-key mode, 128-bit block and key. It holds the working state in a register and, each cycle, applies R_PER_CYCLE rounds through a combinational round datapath: Theta, then Pi1, then the existing Gamma S-box layer, then Pi2. The core feeds Gamma and consumes its output. It connects to its neighbours through valid/ready handshakes on both sides.

---
 rtl/noekeon_pkg.sv | 63 ++++++
 rtl/noekeon_gamma.sv | 28 ++
 rtl/noekeon_round.sv | 25 ++
 rtl/noekeon_encrypt_core.sv | 116 +++++++++++
 tb/tb_noekeon_encrypt_core.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noekeon_pkg.sv
// Noekeon shared definitions: round constants, FSM encoding and the linear
// layers (theta, pi1, pi2) plus the round-constant update.
// State words: a0 = s[31:0], a1 = s[63:32], a2 = s[95:64], a3 = s[127:96].
package noekeon_pkg;

   localparam logic [7:0] RC_INIT    = 8'h80;
   localparam logic [7:0] RC_POLY    = 8'h1B;
   localparam int         NUM_ROUNDS = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   function automatic logic [31:0] word(input logic [127:0] s, input int j);
      return s[32*j +: 32];
   endfunction

   function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] mix8(input logic [31:0] t);
      return t ^ rotl32(t, 8) ^ rotr32(t, 8);
   endfunction

   function automatic logic [127:0] theta(input logic [127:0] s, input logic [127:0] k);
      logic [31:0] a0, a1, a2, a3, t;
      a0 = word(s, 0);
      a1 = word(s, 1);
      a2 = word(s, 2);
      a3 = word(s, 3);
      t  = mix8(a0 ^ a2);
      a1 = a1 ^ t;
      a3 = a3 ^ t;
      a0 = a0 ^ word(k, 0);
      a1 = a1 ^ word(k, 1);
      a2 = a2 ^ word(k, 2);
      a3 = a3 ^ word(k, 3);
      t  = mix8(a1 ^ a3);
      a0 = a0 ^ t;
      a2 = a2 ^ t;
      return {a3, a2, a1, a0};
   endfunction

   function automatic logic [127:0] pi1(input logic [127:0] s);
      return {rotl32(word(s, 3), 2), rotl32(word(s, 2), 5), rotl32(word(s, 1), 1), word(s, 0)};
   endfunction

   function automatic logic [127:0] pi2(input logic [127:0] s);
      return {rotr32(word(s, 3), 2), rotr32(word(s, 2), 5), rotr32(word(s, 1), 1), word(s, 0)};
   endfunction

   function automatic logic [7:0] rc_next(input logic [7:0] rc);
      return {rc[6:0], 1'b0} ^ (rc[7] ? RC_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/noekeon_gamma.sv
// Noekeon Gamma: bit-sliced nonlinear S-box layer across the four words.
// Ports: din (128-bit state in), dout (128-bit state out). Combinational.
module noekeon_gamma
   import noekeon_pkg::*;
(
   input  logic [127:0] din,
   output logic [127:0] dout
);

   logic [31:0] a0, a1, a2, a3, tmp;

   always_comb begin
      a0  = word(din, 0);
      a1  = word(din, 1);
      a2  = word(din, 2);
      a3  = word(din, 3);
      a1  = a1 ^ (~a3 & ~a2);
      a0  = a0 ^ (a2 & a1);
      tmp = a3;
      a3  = a0;
      a0  = tmp;
      a2  = a2 ^ a0 ^ a1 ^ a3;
      a1  = a1 ^ (~a3 & ~a2);
      a0  = a0 ^ (a2 & a1);
      dout = {a3, a2, a1, a0};
   end

endmodule

// File: rtl/noekeon_round.sv
// One Noekeon encryption round: inject rc into a0, Theta(key), Pi1, Gamma, Pi2.
// Ports: state (round input), key (working key), rc (round constant),
//        next_state (round output). Combinational.
module noekeon_round
   import noekeon_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] key,
   input  logic [7:0]   rc,
   output logic [127:0] next_state
);

   logic [127:0] s_pi1;
   logic [127:0] s_gam;

   assign s_pi1 = pi1(theta({state[127:32], state[31:0] ^ {24'h0, rc}}, key));

   noekeon_gamma u_gamma (
      .din  (s_pi1),
      .dout (s_gam)
   );

   assign next_state = pi2(s_gam);

endmodule

// File: rtl/noekeon_encrypt_core.sv
// Iterative Noekeon encryption core (direct-key mode, 128-bit block/key).
// R_PER_CYCLE rounds are chained combinationally per clock.
// Ports: clk, rst_n (async active-low), inValid/inReady/inKey/inData (input
//        handshake), outValid/outReady/outData (output handshake).
//
// state | meaning
// IDLE  | waiting for a plaintext/key pair, inReady=1
// RUN   | applying R_PER_CYCLE rounds per cycle
// DONE  | ciphertext held on outData until outReady
module noekeon_encrypt_core
   import noekeon_pkg::*;
#(
   parameter int R_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inValid,
   output logic         inReady,
   input  logic [127:0] inKey,
   input  logic [127:0] inData,
   output logic         outValid,
   input  logic         outReady,
   output logic [127:0] outData
);

   if (!(R_PER_CYCLE == 1 || R_PER_CYCLE == 2 || R_PER_CYCLE == 4 ||
         R_PER_CYCLE == 8 || R_PER_CYCLE == 16)) begin : g_bad_r
      $error("noekeon_encrypt_core: R_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   localparam logic [4:0] STEP = 5'(R_PER_CYCLE);
   localparam logic [4:0] LAST = 5'(NUM_ROUNDS);

   fsm_t         fsm;
   logic [127:0] state_q;
   logic [127:0] key_q;
   logic [7:0]   rc_q;
   logic [4:0]   cnt_q;

   logic [127:0] chain_state;
   logic [7:0]   chain_rc;
   logic [127:0] final_state;

   // Each stage refers to its predecessor by hierarchical name so the chain
   // is a set of distinct nets rather than one self-referencing array.
   for (genvar i = 0; i < R_PER_CYCLE; i++) begin : g_rnd
      logic [127:0] s_in;
      logic [127:0] s_out;
      logic [7:0]   rc_in;
      logic [7:0]   rc_out;
      if (i == 0) begin : g_first
         assign s_in  = state_q;
         assign rc_in = rc_q;
      end else begin : g_next
         assign s_in  = g_rnd[i-1].s_out;
         assign rc_in = g_rnd[i-1].rc_out;
      end
      noekeon_round u_round (
         .state      (s_in),
         .key        (key_q),
         .rc         (rc_in),
         .next_state (s_out)
      );
      assign rc_out = rc_next(rc_in);
   end

   assign chain_state = g_rnd[R_PER_CYCLE-1].s_out;
   assign chain_rc    = g_rnd[R_PER_CYCLE-1].rc_out;

   // Output transform: on the final cycle chain_rc is rc_16.
   assign final_state = theta({chain_state[127:32], chain_state[31:0] ^ {24'h0, chain_rc}}, key_q);

   assign inReady = (fsm == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm      <= IDLE;
         state_q  <= '0;
         key_q    <= '0;
         rc_q     <= '0;
         cnt_q    <= '0;
         outValid <= 1'b0;
         outData  <= '0;
      end else begin
         unique case (fsm)
            IDLE: begin
               if (inValid) begin
                  state_q <= inData;
                  key_q   <= inKey;
                  rc_q    <= RC_INIT;
                  cnt_q   <= '0;
                  fsm     <= RUN;
               end
            end
            RUN: begin
               state_q <= chain_state;
               rc_q    <= chain_rc;
               cnt_q   <= cnt_q + STEP;
               if (cnt_q + STEP == LAST) begin
                  outData  <= final_state;
                  outValid <= 1'b1;
                  fsm      <= DONE;
               end
            end
            DONE: begin
               if (outReady) begin
                  outValid <= 1'b0;
                  fsm      <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_noekeon_encrypt_core.sv
// Self-checking bench for noekeon_encrypt_core: known vectors, randomized
// blocks with random backpressure, hold/backpressure and mid-run reset.
module tb_noekeon_encrypt_core;

   localparam int R_TB = 1;
   localparam int LAT  = 16 / R_TB;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         inValid = 1'b0;
   logic         inReady;
   logic [127:0] inKey = '0;
   logic [127:0] inData = '0;
   logic         outValid;
   logic         outReady = 1'b0;
   logic [127:0] outData;

   noekeon_encrypt_core #(.R_PER_CYCLE(R_TB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .inValid  (inValid),
      .inReady  (inReady),
      .inKey    (inKey),
      .inData   (inData),
      .outValid (outValid),
      .outReady (outReady),
      .outData  (outData)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit rnd_ready = 1'b0;
   bit cur_active = 1'b0;
   logic [127:0] cur_exp;
   logic [127:0] exp_q[$];
   int           acc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rnd_ready) outReady = ($urandom_range(0, 3) != 0);
   end

   task automatic check128(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Reference model: word-array Noekeon with a generated constant schedule.
   function automatic logic [31:0] rl(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x};
      if (n % 32 == 0) return x;
      return d[63 - (n % 32) -: 32];
   endfunction

   function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] p);
      logic [31:0] a [4];
      logic [31:0] kw [4];
      logic [31:0] t;
      logic [7:0]  rc;
      int          rot [4];
      rot = '{0, 1, 5, 2};
      for (int j = 0; j < 4; j++) begin
         a[j]  = p[32*j +: 32];
         kw[j] = k[32*j +: 32];
      end
      rc = 8'h80;
      for (int r = 0; r <= 16; r++) begin
         a[0] ^= {24'h0, rc};
         t = a[0] ^ a[2];
         t ^= rl(t, 8) ^ rl(t, 24);
         a[1] ^= t;
         a[3] ^= t;
         for (int j = 0; j < 4; j++) a[j] ^= kw[j];
         t = a[1] ^ a[3];
         t ^= rl(t, 8) ^ rl(t, 24);
         a[0] ^= t;
         a[2] ^= t;
         if (r == 16) break;
         for (int j = 1; j < 4; j++) a[j] = rl(a[j], rot[j]);
         a[1] ^= ~a[3] & ~a[2];
         a[0] ^= a[2] & a[1];
         t = a[3]; a[3] = a[0]; a[0] = t;
         a[2] ^= a[0] ^ a[1] ^ a[3];
         a[1] ^= ~a[3] & ~a[2];
         a[0] ^= a[2] & a[1];
         for (int j = 1; j < 4; j++) a[j] = rl(a[j], 32 - rot[j]);
         rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
      end
      return {a[3], a[2], a[1], a[0]};
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Monitor: pop expected on first sight of each result, then check it holds.
   always @(negedge clk) begin
      if (!rst_n) begin
         cur_active = 1'b0;
      end else if (outValid) begin
         if (!cur_active) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: outValid with no pending block, data %h", outData);
            end else begin
               cur_exp = exp_q.pop_front();
               check128("ciphertext", outData, cur_exp);
               check_int("latency", cyc - acc_q.pop_front(), LAT);
               cur_active = 1'b1;
            end
         end else begin
            check128("outData_hold", outData, cur_exp);
         end
         check1("inReady_busy", inReady, 1'b0);
         if (outReady) cur_active = 1'b0;
      end
   end

   task automatic send(input logic [127:0] k, input logic [127:0] p, input logic [127:0] e);
      int n;
      n = 0;
      @(posedge clk); #1;
      inValid = 1'b1;
      inKey   = k;
      inData  = p;
      @(negedge clk);
      while (!inReady && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!inReady) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: inReady %b required 1", inReady);
         inValid = 1'b0;
         return;
      end
      exp_q.push_back(e);
      acc_q.push_back(cyc + 1);
      @(posedge clk); #1;
      inValid = 1'b0;
      inKey   = rnd128();
      inData  = rnd128();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || outValid) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_int("drain_pending", exp_q.size(), 0);
   endtask

   localparam logic [128*9-1:0] VEC = {
      128'h0, 128'h0, 128'h503d2dfc_24b70148_699e29fa_b1656851,
      {128{1'b1}}, {128{1'b1}}, 128'h1d1349b2_4f26113f_87c7d092_2a78421b,
      128'h503d2dfc_24b70148_699e29fa_b1656851, 128'h1d1349b2_4f26113f_87c7d092_2a78421b,
      128'hbc47532c_fc372233_7b75660f_e2f687e0};

   initial begin
      logic [128*9-1:0] vec;
      logic [127:0] k, p, e, held;
      int n;
      vec = VEC;

      #2;
      check1("reset_inReady", inReady, 1'b1);
      check1("reset_outValid", outValid, 1'b0);
      check128("reset_outData", outData, 128'h0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Model sanity against the published vectors, then DUT on the same.
      for (int v = 0; v < 3; v++) begin
         k = vec[128*(8-3*v) +: 128];
         p = vec[128*(7-3*v) +: 128];
         e = vec[128*(6-3*v) +: 128];
         check128("model_vector", ref_encrypt(k, p), e);
      end
      outReady = 1'b1;
      for (int v = 0; v < 3; v++) begin
         k = vec[128*(8-3*v) +: 128];
         p = vec[128*(7-3*v) +: 128];
         e = vec[128*(6-3*v) +: 128];
         send(k, p, e);
      end
      drain();

      // Randomized blocks with random gaps and random backpressure.
      rnd_ready = 1'b1;
      for (int b = 0; b < 20; b++) begin
         k = rnd128();
         p = rnd128();
         send(k, p, ref_encrypt(k, p));
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      drain();

      // Hold: outReady low for 10 cycles while new inValid is offered.
      rnd_ready = 1'b0;
      @(posedge clk); #2;
      outReady = 1'b0;
      k = rnd128();
      p = rnd128();
      held = ref_encrypt(k, p);
      send(k, p, held);
      n = 0;
      while (!outValid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check1("hold_outValid", outValid, 1'b1);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         inValid = 1'b1;
         inData  = rnd128();
         @(negedge clk);
         check1("hold_inReady", inReady, 1'b0);
         check1("hold_valid", outValid, 1'b1);
      end
      @(posedge clk); #1;
      inValid  = 1'b0;
      outReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check1("release_inReady", inReady, 1'b1);
      check1("release_outValid", outValid, 1'b0);
      check128("release_outData_kept", outData, held);
      repeat (LAT + 4) @(negedge clk);
      check1("no_extra_block", outValid, 1'b0);
      check_int("no_extra_pending", exp_q.size(), 0);

      // Mid-run reset aborts the block with no result.
      k = vec[128*8 +: 128];
      p = vec[128*7 +: 128];
      send(k, p, vec[128*6 +: 128]);
      repeat ((LAT > 7) ? 6 : 0) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      exp_q.delete();
      acc_q.delete();
      check1("abort_outValid", outValid, 1'b0);
      check128("abort_outData", outData, 128'h0);
      check1("abort_inReady", inReady, 1'b1);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (LAT + 3) @(negedge clk);
      check1("abort_no_output", outValid, 1'b0);
      send(k, p, vec[128*6 +: 128]);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
